// File: rtl/data_bus_responder_pkg.sv
// rtl/data_bus_responder_pkg.sv - shared MMIO register map and TX status layout for the data bus responder
package data_bus_responder_pkg;

  localparam int DATA_ADDR_WIDTH = 16;

  // MMIO register select, taken from dataAddr[3:2]
  typedef enum logic [1:0] {
    MMIO_LED   = 2'd0,
    MMIO_CYCLE = 2'd1,
    MMIO_TX    = 2'd2,
    MMIO_CTRL  = 2'd3
  } mmio_reg_e;

  // TX status word bit positions
  localparam int TX_STAT_FULL      = 0;
  localparam int TX_STAT_EMPTY     = 1;
  localparam int TX_STAT_OVERFLOW  = 2;
  localparam int TX_STAT_COUNT_LSB = 3;
  localparam int TX_STAT_COUNT_W   = 5;

  // CTRL write bit that clears the sticky overflow flag
  localparam int CTRL_CLR_OVERFLOW = 0;

  function automatic logic [31:0] tx_status(input logic full, input logic empty,
                                            input logic overflow, input logic [4:0] count);
    logic [31:0] s;
    s = '0;
    s[TX_STAT_FULL]     = full;
    s[TX_STAT_EMPTY]    = empty;
    s[TX_STAT_OVERFLOW] = overflow;
    s[TX_STAT_COUNT_LSB +: TX_STAT_COUNT_W] = count;
    return s;
  endfunction

endpackage

// File: rtl/data_bus_responder_tx_fifo.sv
// rtl/data_bus_responder_tx_fifo.sv - circular byte FIFO with registered head byte/valid and sticky overflow
module tx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  input  logic          clear_overflow,
  output logic [7:0]    head_data,
  output logic          head_valid,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          pop_ok;
  logic          push_ok;
  logic [AW-1:0] rd_ptr_next;
  logic [CW-1:0] count_next;
  logic [7:0]    head_next;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Accept/pop decisions and the next head byte, so head_data can be a plain register
  always_comb begin
    pop_ok      = pop && head_valid;
    push_ok     = push && (!full || pop_ok);
    rd_ptr_next = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    count_next  = count;
    if (push_ok && !pop_ok) count_next = count + CW'(1);
    if (!push_ok && pop_ok) count_next = count - CW'(1);
    // A byte written this cycle into the slot that becomes the head must bypass the array
    if (count_next == '0)
      head_next = 8'h00;
    else if (push_ok && (wr_ptr == rd_ptr_next))
      head_next = push_data;
    else
      head_next = mem[rd_ptr_next];
  end

  // Storage array; contents are don't-care while empty so no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers, count, overflow flag and registered head outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      head_data  <= 8'h00;
      head_valid <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_next;
      count      <= count_next;
      head_data  <= head_next;
      head_valid <= (count_next != '0);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push && !push_ok) overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - CPU data-port responder: RAM plus LED/CYCLE/TX FIFO MMIO; option macro DATA_BUS_CYCLE_COUNTER_EN
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int TX_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_ADDR_WIDTH-1:0] dataAddr,
  input  logic [31:0]                dataOut,
  input  logic                       dataWrEnable,
  output logic [31:0]                dataIn,
  output logic [7:0]                 led,
  output logic [7:0]                 txData,
  output logic                       txValid,
  input  logic                       txReady
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int FIFO_CW = $clog2(TX_DEPTH) + 1;

  logic [31:0]       ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic              is_mmio;
  mmio_reg_e         reg_sel;
  logic              ram_we;
  logic              mmio_we;
  logic [31:0]       cycle_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_CW-1:0] fifo_count;
  logic              fifo_overflow;
  logic              unused_bits;

  assign is_mmio = dataAddr[DATA_ADDR_WIDTH-1];
  assign ram_idx = dataAddr[RAM_AW+1:2];
  assign reg_sel = mmio_reg_e'(dataAddr[3:2]);
  assign ram_we  = dataWrEnable && !is_mmio;
  assign mmio_we = dataWrEnable && is_mmio;

  assign unused_bits = ^{dataAddr[1:0], dataAddr[DATA_ADDR_WIDTH-2:RAM_AW+2], dataOut[31:8]};

  // Data RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= dataOut;
  end

  // LED register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led <= 8'h00;
    else if (mmio_we && reg_sel == MMIO_LED) led <= dataOut[7:0];
  end

`ifdef DATA_BUS_CYCLE_COUNTER_EN
  // Free-running cycle counter; a write clears it ahead of the increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cycle_count <= '0;
    else if (mmio_we && reg_sel == MMIO_CYCLE) cycle_count <= '0;
    else cycle_count <= cycle_count + 32'd1;
  end
`else
  assign cycle_count = '0;
`endif

  tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk            (clk),
    .rst            (rst),
    .push           (mmio_we && reg_sel == MMIO_TX),
    .push_data      (dataOut[7:0]),
    .pop            (txValid && txReady),
    .clear_overflow (mmio_we && reg_sel == MMIO_CTRL && dataOut[CTRL_CLR_OVERFLOW]),
    .head_data      (txData),
    .head_valid     (txValid),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .count          (fifo_count),
    .overflow       (fifo_overflow)
  );

  // Combinational read mux over RAM and the MMIO window
  always_comb begin
    dataIn = '0;
    if (!is_mmio) begin
      dataIn = ram[ram_idx];
    end else begin
      case (reg_sel)
        MMIO_LED:   dataIn = {24'h0, led};
        MMIO_CYCLE: dataIn = cycle_count;
        MMIO_TX:    dataIn = tx_status(fifo_full, fifo_empty, fifo_overflow, 5'(fifo_count));
        default:    dataIn = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - table-driven self-checking bench for data_bus_responder
module tb_data_bus_responder;

  logic        clk;
  logic        rst;
  logic [15:0] dataAddr;
  logic [31:0] dataOut;
  logic        dataWrEnable;
  logic [31:0] dataIn;
  logic [7:0]  led;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;

  int n_checks;
  int n_fail;

  data_bus_responder dut (
    .clk          (clk),
    .rst          (rst),
    .dataAddr     (dataAddr),
    .dataOut      (dataOut),
    .dataWrEnable (dataWrEnable),
    .dataIn       (dataIn),
    .led          (led),
    .txData       (txData),
    .txValid      (txValid),
    .txReady      (txReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        chk_rd;
    logic [31:0] rd;
    logic [7:0]  led;
    logic        valid;
    logic [7:0]  txd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic we, input logic [15:0] addr,
                     input logic [31:0] wdata, input logic ready, input logic chk_rd,
                     input logic [31:0] rd, input logic [7:0] l, input logic valid,
                     input logic [7:0] txd);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.ready = ready;
    v.chk_rd = chk_rd; v.rd = rd; v.led = l; v.valid = valid; v.txd = txd;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [15:0] A_LED   = 16'h8000;
  localparam logic [15:0] A_CYCLE = 16'h8004;
  localparam logic [15:0] A_TX    = 16'h8008;
  localparam logic [15:0] A_CTRL  = 16'h800C;

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //   name         we addr    wdata         rdy chk rd            led    vld txd
    add("rst_status", 0, A_TX,   32'h0,        0,  1,  32'h00000002, 8'h00, 0, 8'h00);
    add("ram_wr",     1, 16'h10, 32'hDEADBEEF, 0,  0,  32'h0,        8'h00, 0, 8'h00);
    add("ram_wr2",    1, 16'h14, 32'h12345678, 0,  0,  32'h0,        8'h00, 0, 8'h00);
    add("ram_rd",     0, 16'h10, 32'h0,        0,  1,  32'hDEADBEEF, 8'h00, 0, 8'h00);
    add("ram_alias",  0, 16'h13, 32'h0,        0,  1,  32'hDEADBEEF, 8'h00, 0, 8'h00);
    add("ram_rd2",    0, 16'h16, 32'h0,        0,  1,  32'h12345678, 8'h00, 0, 8'h00);
    add("led_wr",     1, A_LED,  32'h000001A5, 0,  1,  32'h00000000, 8'h00, 0, 8'h00);
    add("led_rd",     0, A_LED,  32'h0,        0,  1,  32'h000000A5, 8'hA5, 0, 8'h00);
    add("ctrl_rd",    0, A_CTRL, 32'h0,        0,  1,  32'h00000000, 8'hA5, 0, 8'h00);
    add("push41",     1, A_TX,   32'h41,       0,  1,  32'h00000002, 8'hA5, 0, 8'h00);
    add("push42",     1, A_TX,   32'h42,       0,  1,  32'h00000008, 8'hA5, 1, 8'h41);
    add("push43",     1, A_TX,   32'h43,       0,  1,  32'h00000010, 8'hA5, 1, 8'h41);
    add("push44",     1, A_TX,   32'h44,       0,  1,  32'h00000018, 8'hA5, 1, 8'h41);
    add("push45",     1, A_TX,   32'h45,       0,  1,  32'h00000021, 8'hA5, 1, 8'h41);
    add("full_stat",  0, A_TX,   32'h0,        0,  1,  32'h00000025, 8'hA5, 1, 8'h41);
    add("drain41",    0, A_TX,   32'h0,        1,  1,  32'h00000025, 8'hA5, 1, 8'h41);
    add("drain42",    0, A_TX,   32'h0,        1,  1,  32'h0000001C, 8'hA5, 1, 8'h42);
    add("drain43",    0, A_TX,   32'h0,        1,  1,  32'h00000014, 8'hA5, 1, 8'h43);
    add("drain44",    0, A_TX,   32'h0,        1,  1,  32'h0000000C, 8'hA5, 1, 8'h44);
    add("drained",    0, A_TX,   32'h0,        1,  1,  32'h00000006, 8'hA5, 0, 8'h00);
    add("clr_ovf",    1, A_CTRL, 32'h1,        0,  1,  32'h00000000, 8'hA5, 0, 8'h00);
    add("clr_stat",   0, A_TX,   32'h0,        0,  1,  32'h00000002, 8'hA5, 0, 8'h00);
    add("push51",     1, A_TX,   32'h51,       0,  1,  32'h00000002, 8'hA5, 0, 8'h00);
    add("push52",     1, A_TX,   32'h52,       0,  1,  32'h00000008, 8'hA5, 1, 8'h51);
    add("push53",     1, A_TX,   32'h53,       0,  1,  32'h00000010, 8'hA5, 1, 8'h51);
    add("push54",     1, A_TX,   32'h54,       0,  1,  32'h00000018, 8'hA5, 1, 8'h51);
    add("push55_pop", 1, A_TX,   32'h55,       1,  1,  32'h00000021, 8'hA5, 1, 8'h51);
    add("after55",    0, A_TX,   32'h0,        0,  1,  32'h00000021, 8'hA5, 1, 8'h52);
    add("drain52",    0, A_TX,   32'h0,        1,  1,  32'h00000021, 8'hA5, 1, 8'h52);
    add("drain53",    0, A_TX,   32'h0,        1,  1,  32'h00000018, 8'hA5, 1, 8'h53);
    add("drain54",    0, A_TX,   32'h0,        1,  1,  32'h00000010, 8'hA5, 1, 8'h54);
    add("drain55",    0, A_TX,   32'h0,        1,  1,  32'h00000008, 8'hA5, 1, 8'h55);
    add("empty2",     0, A_TX,   32'h0,        1,  1,  32'h00000002, 8'hA5, 0, 8'h00);

    rst = 1'b0;
    dataAddr = A_TX;
    dataOut = '0;
    dataWrEnable = 1'b0;
    txReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", {24'h0, led}, 32'h0);
    check("rst_valid", {31'h0, txValid}, 32'h0);
    check("rst_txdata", {24'h0, txData}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      dataWrEnable = vecs[i].we;
      dataAddr     = vecs[i].addr;
      dataOut      = vecs[i].wdata;
      txReady      = vecs[i].ready;
      @(negedge clk);
      if (vecs[i].chk_rd) check({vecs[i].name, "_rd"}, dataIn, vecs[i].rd);
      check({vecs[i].name, "_led"}, {24'h0, led}, {24'h0, vecs[i].led});
      check({vecs[i].name, "_valid"}, {31'h0, txValid}, {31'h0, vecs[i].valid});
      if (vecs[i].valid) check({vecs[i].name, "_txd"}, {24'h0, txData}, {24'h0, vecs[i].txd});
      @(posedge clk);
      #1;
    end
    dataWrEnable = 1'b0;
    txReady = 1'b0;

    // CYCLE: clear at edge N, read 0 in N+1, 1 in N+2, 10 ten cycles after the clear
    dataAddr = A_CYCLE;
    dataOut = 32'hFFFF_FFFF;
    dataWrEnable = 1'b1;
    @(posedge clk);
    #1;
    dataWrEnable = 1'b0;
    @(negedge clk);
`ifdef DATA_BUS_CYCLE_COUNTER_EN
    check("cycle_n1", dataIn, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("cycle_n2", dataIn, 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("cycle_10", dataIn, 32'd10);
`else
    check("cycle_n1", dataIn, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("cycle_n2", dataIn, 32'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("cycle_10", dataIn, 32'd0);
`endif
    @(posedge clk);
    #1;

    // Reset asserted mid-drain discards the queue immediately
    dataAddr = A_TX;
    dataWrEnable = 1'b1;
    dataOut = 32'h61;
    @(posedge clk);
    #1;
    dataOut = 32'h62;
    @(posedge clk);
    #1;
    dataWrEnable = 1'b0;
    txReady = 1'b1;
    @(negedge clk);
    check("mid_valid_pre", {31'h0, txValid}, 32'h1);
    check("mid_txd_pre", {24'h0, txData}, 32'h61);
    #1;
    rst = 1'b0;
    #1;
    check("mid_valid_rst", {31'h0, txValid}, 32'h0);
    check("mid_txd_rst", {24'h0, txData}, 32'h0);
    check("mid_led_rst", {24'h0, led}, 32'h0);
    check("mid_status_rst", dataIn, 32'h00000002);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_status", dataIn, 32'h00000002);
    check("post_rst_valid", {31'h0, txValid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Responder side of the CPU data port: decodes the byte address, write data and write enable driven by the CPU and returns read data on the same cycle. It contains the data RAM plus a small memory-mapped I/O window: an LED register, a cycle counter and a 4-entry byte FIFO. The FIFO drains to an external sink through a valid/ready handshake. It sits beside the instruction memory at the top level, wired directly to the CPU data-bus outputs and `dataIn`.

## Interface
- `RAM_WORDS`, 1024: RAM depth in 32-bit words; must be a power of two.
- `TX_DEPTH`, 4: TX FIFO depth; must be a power of two and ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `dataAddr`  in  `DATA_ADDR_WIDTH`  byte address from the CPU.
- `dataOut`  in  32  write data from the CPU.
- `dataWrEnable`  in  1  write strobe from the CPU.
- `dataIn`  out  32  read data to the CPU; combinational.
- `led`  out  8  LED register contents.
- `txData`  out  8  FIFO head byte.
- `txValid`  out  1  FIFO is non-empty.
- `txReady`  in  1  sink accepts the head byte.

## Operation
- **Region select.** `dataAddr[DATA_ADDR_WIDTH-1]` picks the region: 0 = RAM, 1 = MMIO. Bits [1:0] are ignored, so there is no byte or halfword access.
- **RAM.**
  - Word index = `dataAddr[log2(RAM_WORDS)+1:2]`; upper bits alias.
  - Read is combinational.
  - Write happens at the edge when `dataWrEnable`=1.
  - RAM contents are not reset.
- **MMIO.** Register select = `dataAddr[3:2]`.
  - 0, LED: R/W. A write stores `dataOut[7:0]`. A read returns it zero-extended.
  - 1, CYCLE: read returns a 32-bit counter that increments every cycle and wraps from 0xFFFFFFFF to 0. A write loads 0, and that takes priority over the increment.
  - 2, TX: a write pushes `dataOut[7:0]`. A read returns status:
    - bit0 full
    - bit1 empty
    - bit2 overflow (sticky)
    - bits[7:3] count
    - all other bits 0
  - 3, CTRL: a write with `dataOut[0]`=1 clears overflow. Reads return 0.
- **TX FIFO.** Circular buffer with read/write pointers plus a count.
  - Pop happens when `txValid && txReady`.
  - A push is accepted when count < `TX_DEPTH`, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped, overflow is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo `TX_DEPTH`.
- A write to reserved bits or to an unimplemented address has no effect.

## Timing
- **Reset** (`rst`=0, asynchronous), all held until `rst` returns to 1:
  - `led` = 0, CYCLE = 0, FIFO empty, pointers 0, overflow = 0.
  - Outputs: `txValid` = 0, `txData` = 0.
  - `dataIn` still reflects the current address.
- **Read latency:** 0 cycles. `dataIn` is valid in the same cycle that `dataAddr` is stable.
- **Write latency:** 1 edge. A read of the same location in the following cycle returns the new value.
- **CYCLE reads:** the value read is the pre-edge count. A write of CYCLE at edge N makes the read in cycle N+1 return 0, and cycle N+2 return 1.
- **TX handshake:**
  - `txData`/`txValid` are registered outputs of FIFO state.
  - `txValid` rises 1 cycle after the first push into an empty FIFO.
  - `txData` must stay stable while `txValid`=1 and `txReady`=0.
- **Reset mid-transfer:** a reset asserted while `txValid`=1 discards all queued bytes. The sink must tolerate `txValid` dropping without a handshake.

## Configuration
- `DATA_BUS_CYCLE_COUNTER_EN`
  - Defined: CYCLE behaves as described above.
  - Undefined: the counter register is not instantiated, CYCLE reads 0, and writes to it are ignored.
  - All other behaviour is identical in both builds.

## Structure
- **Shared package:** MMIO register indices (`MMIO_LED`, `MMIO_CYCLE`, `MMIO_TX`, `MMIO_CTRL`) and the status bit positions. These belong with the existing `Types.v` definitions so that software tests and the bench share them.
- **Sub-module:** the FIFO is a natural sub-module, `tx_fifo`, parameterised by depth, with push/pop/full/empty/count/overflow ports.
- **Top level:** the RAM array and the address decode stay in the top module.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles. Expect `led`=0, `txValid`=0; a read of TX status returns 0x00000002.
- **RAM:** write 0xDEADBEEF to byte address 0x0010. Expect the read at 0x0010 to return 0xDEADBEEF next cycle, and 0x0013 to alias to the same word.
- **LED:** write 0x1A5 to LED. Expect `led`=0xA5 and a read of 0x000000A5.
- **FIFO fill and drain:**
  - With `txReady`=0, push 0x41..0x45. Expect status full=1, count=4, overflow=1.
  - Raise `txReady`. Expect `txData` sequence 0x41, 0x42, 0x43, 0x44, then `txValid`=0.
- **Simultaneous push and pop:** with the FIFO full and `txReady`=1, push 0x55. Expect it to be accepted, count to stay 4, overflow unchanged, and 0x55 to emerge last.
- **CYCLE** (macro defined): write CYCLE, wait 10 cycles, read. Expect 10. With the macro undefined, expect 0. Assert reset mid-drain and expect an immediate `txValid`=0.
